// File: rtl/lsu_mem_stage.sv
// Memory stage of the load/store pipeline: holds one instruction, waits for the
// load response and aligns/extends the returned data before handing off to writeback.
module lsu_mem_stage #(
    parameter int XLEN = 64,
    parameter int ES_W = 2*XLEN+10,
    parameter int WS_W = 2*XLEN+6
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            ws_allowin,
    output logic            ms_allowin,
    input  logic            es_to_ms_valid,
    input  logic [ES_W-1:0] es_to_ms_bus,
    input  logic            data_rdata_valid,
    input  logic [XLEN-1:0] data_rdata,
    output logic            ms_to_ws_valid,
    output logic [WS_W-1:0] ms_to_ws_bus,
    output logic [XLEN+6:0] ms_fwd_bus,
    output logic [XLEN-1:0] debug_ms_pc,
    output logic [4:0]      debug_ms_dest,
    output logic [XLEN-1:0] debug_ms_final_result
);

    localparam int OFF_W = $clog2(XLEN/8);

    logic            ms_valid;
    logic            resp_got;
    logic [ES_W-1:0] es_bus_r;
    logic [XLEN-1:0] hold_data;

    logic            ld_unsigned;
    logic [1:0]      ld_size;
    logic            is_load;
    logic            gr_we;
    logic [4:0]      dest;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc;

    assign {ld_unsigned, ld_size, is_load, gr_we, dest, alu_result, pc} = es_bus_r;

    logic ms_ready_go;
    logic load_in;
    logic leave;
    logic resp_accept;

    assign ms_ready_go    = !is_load || resp_got || data_rdata_valid;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign load_in        = ms_allowin && es_to_ms_valid;
    assign leave          = ms_to_ws_valid && ws_allowin;
    assign resp_accept    = ms_valid && is_load && !resp_got && data_rdata_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid  <= 1'b0;
            resp_got  <= 1'b0;
            hold_data <= '0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (load_in || leave) begin
                resp_got <= 1'b0;
            end else if (resp_accept) begin
                resp_got  <= 1'b1;
                hold_data <= data_rdata;
            end
        end
    end

    // Payload only matters while ms_valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_in) begin
            es_bus_r <= es_to_ms_bus;
        end
    end

    logic [1:0]       sz;
    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] lane;
    logic [XLEN-1:0]  raw;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  mask;
    logic [XLEN-1:0]  load_ext;
    logic             sign;
    logic [XLEN-1:0]  final_result;

    // A 32-bit datapath has no double loads; size 3 degrades to a full word.
    assign sz  = (XLEN == 32 && ld_size == 2'd3) ? 2'd2 : ld_size;
    assign off = alu_result[OFF_W-1:0];
    assign raw = resp_got ? hold_data : data_rdata;

    always_comb begin
        lane = off;
        mask = '1;
        case (sz)
            2'd0: begin
                lane = off;
                mask = XLEN'(8'hFF);
            end
            2'd1: begin
                lane = off & ~OFF_W'(1);
                mask = XLEN'(16'hFFFF);
            end
            2'd2: begin
                lane = off & ~OFF_W'(3);
                mask = XLEN'(32'hFFFF_FFFF);
            end
            default: begin
                lane = '0;
                mask = '1;
            end
        endcase
        shifted = raw >> {lane, 3'b000};
        case (sz)
            2'd0:    sign = shifted[7];
            2'd1:    sign = shifted[15];
            2'd2:    sign = shifted[31];
            default: sign = 1'b0;
        endcase
        // A full-width mask leaves ~mask empty, so ld_unsigned has no effect there.
        load_ext = shifted & mask;
        if (!ld_unsigned && sign) begin
            load_ext = load_ext | ~mask;
        end
    end

    assign final_result = is_load ? load_ext : alu_result;

    assign ms_to_ws_bus          = {gr_we, dest, final_result, pc};
    assign ms_fwd_bus            = {ms_valid && gr_we, ms_ready_go, dest, final_result};
    assign debug_ms_pc           = pc;
    assign debug_ms_dest         = dest;
    assign debug_ms_final_result = final_result;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: load extraction table plus stall, back-to-back,
// reset and 32-bit datapath sequences.
module tb_lsu_mem_stage;

    logic clk;
    logic resetn;

    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_valid;
    logic [137:0] es_bus;
    logic         rdv;
    logic [63:0]  rdata;
    logic         ws_valid;
    logic [133:0] ws_bus;
    logic [70:0]  fwd_bus;
    logic [63:0]  dbg_pc;
    logic [4:0]   dbg_dest;
    logic [63:0]  dbg_res;

    logic         ws_allowin32;
    logic         ms_allowin32;
    logic         es_valid32;
    logic [73:0]  es_bus32;
    logic         rdv32;
    logic [31:0]  rdata32;
    logic         ws_valid32;
    logic [69:0]  ws_bus32;
    logic [38:0]  fwd_bus32;
    logic [31:0]  dbg_pc32;
    logic [4:0]   dbg_dest32;
    logic [31:0]  dbg_res32;

    int n_chk  = 0;
    int n_fail = 0;

    lsu_mem_stage #(.XLEN(64)) u64 (
        .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_valid), .es_to_ms_bus(es_bus),
        .data_rdata_valid(rdv), .data_rdata(rdata),
        .ms_to_ws_valid(ws_valid), .ms_to_ws_bus(ws_bus), .ms_fwd_bus(fwd_bus),
        .debug_ms_pc(dbg_pc), .debug_ms_dest(dbg_dest), .debug_ms_final_result(dbg_res)
    );

    lsu_mem_stage #(.XLEN(32)) u32 (
        .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin32), .ms_allowin(ms_allowin32),
        .es_to_ms_valid(es_valid32), .es_to_ms_bus(es_bus32),
        .data_rdata_valid(rdv32), .data_rdata(rdata32),
        .ms_to_ws_valid(ws_valid32), .ms_to_ws_bus(ws_bus32), .ms_fwd_bus(fwd_bus32),
        .debug_ms_pc(dbg_pc32), .debug_ms_dest(dbg_dest32), .debug_ms_final_result(dbg_res32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        us;
        logic [1:0]  sz;
        logic [63:0] alu;
        logic [63:0] rdata;
        int          delay;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [137:0] mk_bus(input logic us, input logic [1:0] sz, input logic ld,
                                            input logic we, input logic [4:0] d,
                                            input logic [63:0] alu, input logic [63:0] pc);
        return {us, sz, ld, we, d, alu, pc};
    endfunction

    function automatic logic [73:0] mk_bus32(input logic us, input logic [1:0] sz, input logic ld,
                                             input logic we, input logic [4:0] d,
                                             input logic [31:0] alu, input logic [31:0] pc);
        return {us, sz, ld, we, d, alu, pc};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        es_valid = 1'b1;
        es_bus   = mk_bus(v.us, v.sz, 1'b1, 1'b1, 5'd7, v.alu, 64'h1000 + 64'(idx));
        #1 chk({nm, " entry allowin"}, 64'(ms_allowin), 64'd1);
        step();
        es_valid = 1'b0;
        for (int i = 0; i < v.delay; i++) begin
            #1;
            chk({nm, " wait valid"}, 64'(ws_valid), 64'd0);
            chk({nm, " wait fwd_ready"}, 64'(fwd_bus[69]), 64'd0);
            step();
        end
        rdv   = 1'b1;
        rdata = v.rdata;
        #1;
        chk({nm, " resp valid"}, 64'(ws_valid), 64'd1);
        chk({nm, " result"}, ws_bus[127:64], v.exp);
        chk({nm, " pc"}, ws_bus[63:0], 64'h1000 + 64'(idx));
        step();
        rdv   = 1'b0;
        rdata = '0;
        #1 chk({nm, " drained"}, 64'(ws_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        vecs[0]  = '{1'b0, 2'd0, 64'h3, 64'h00000000_80000000, 2, 64'hFFFFFFFF_FFFFFF80};
        vecs[1]  = '{1'b1, 2'd1, 64'h6, 64'hBEEF0000_00000000, 1, 64'h00000000_0000BEEF};
        vecs[2]  = '{1'b0, 2'd1, 64'h7, 64'hBEEF0000_00000000, 0, 64'hFFFFFFFF_FFFFBEEF};
        vecs[3]  = '{1'b0, 2'd2, 64'h5, 64'h89ABCDEF_01234567, 0, 64'hFFFFFFFF_89ABCDEF};
        vecs[4]  = '{1'b1, 2'd2, 64'h4, 64'h89ABCDEF_01234567, 1, 64'h00000000_89ABCDEF};
        vecs[5]  = '{1'b0, 2'd3, 64'h3, 64'h80000000_00000001, 0, 64'h80000000_00000001};
        vecs[6]  = '{1'b1, 2'd0, 64'h0, 64'h11223344_556677FE, 0, 64'h00000000_000000FE};
        vecs[7]  = '{1'b0, 2'd0, 64'h1, 64'h11223344_556677FE, 0, 64'h00000000_00000077};
        vecs[8]  = '{1'b0, 2'd2, 64'h0, 64'h11223344_7FFFFFFF, 0, 64'h00000000_7FFFFFFF};
        vecs[9]  = '{1'b1, 2'd3, 64'h10, 64'hFEDCBA98_76543210, 3, 64'hFEDCBA98_76543210};
        vecs[10] = '{1'b0, 2'd0, 64'h7, 64'hC1000000_00000000, 0, 64'hFFFFFFFF_FFFFFFC1};

        resetn = 1'b0;
        ws_allowin = 1'b1; es_valid = 1'b0; es_bus = '0; rdv = 1'b0; rdata = '0;
        ws_allowin32 = 1'b1; es_valid32 = 1'b0; es_bus32 = '0; rdv32 = 1'b0; rdata32 = '0;
        repeat (3) step();
        chk("reset allowin", 64'(ms_allowin), 64'd1);
        chk("reset ws_valid", 64'(ws_valid), 64'd0);
        chk("reset fwd_valid", 64'(fwd_bus[70]), 64'd0);
        chk("reset ws_valid32", 64'(ws_valid32), 64'd0);
        resetn = 1'b1;
        step();

        // Single ALU op
        es_valid = 1'b1;
        es_bus   = mk_bus(1'b0, 2'd0, 1'b0, 1'b1, 5'd2, 64'd20, 64'd1);
        step();
        es_valid = 1'b0;
        #1;
        chk("alu valid", 64'(ws_valid), 64'd1);
        chk("alu result", ws_bus[127:64], 64'd20);
        chk("alu dest", 64'(ws_bus[132:128]), 64'd2);
        chk("alu pc", ws_bus[63:0], 64'd1);
        chk("alu gr_we", 64'(ws_bus[133]), 64'd1);
        chk("alu fwd_valid", 64'(fwd_bus[70]), 64'd1);
        chk("alu fwd_ready", 64'(fwd_bus[69]), 64'd1);
        chk("alu dbg_res", dbg_res, 64'd20);
        step();
        chk("alu drained", 64'(ws_valid), 64'd0);

        for (int i = 0; i < 11; i++) begin
            run_load(vecs[i], i);
            step();
        end

        // Response during writeback stall is held; spurious later response ignored
        es_valid = 1'b1;
        es_bus   = mk_bus(1'b1, 2'd1, 1'b1, 1'b1, 5'd3, 64'h6, 64'h200);
        step();
        es_valid   = 1'b0;
        ws_allowin = 1'b0;
        rdv = 1'b1; rdata = 64'hBEEF0000_00000000;
        #1;
        chk("stall resp valid", 64'(ws_valid), 64'd1);
        chk("stall resp allowin", 64'(ms_allowin), 64'd0);
        chk("stall resp result", ws_bus[127:64], 64'h0000_0000_0000_BEEF);
        step();
        rdata = 64'h1234_5678_9ABC_DEF0;
        #1 chk("stall spurious result", ws_bus[127:64], 64'h0000_0000_0000_BEEF);
        step();
        rdv = 1'b0; rdata = '0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall hold valid", 64'(ws_valid), 64'd1);
            chk("stall hold result", ws_bus[127:64], 64'h0000_0000_0000_BEEF);
            chk("stall hold allowin", 64'(ms_allowin), 64'd0);
            step();
        end
        ws_allowin = 1'b1;
        es_valid   = 1'b1;
        es_bus     = mk_bus(1'b0, 2'd0, 1'b0, 1'b1, 5'd4, 64'd55, 64'h204);
        #1;
        chk("release allowin", 64'(ms_allowin), 64'd1);
        chk("release valid", 64'(ws_valid), 64'd1);
        chk("release result", ws_bus[127:64], 64'h0000_0000_0000_BEEF);
        step();
        es_valid = 1'b0;
        #1;
        chk("follow-on valid", 64'(ws_valid), 64'd1);
        chk("follow-on result", ws_bus[127:64], 64'd55);
        chk("follow-on dest", 64'(dbg_dest), 64'd4);
        step();
        chk("follow-on drained", 64'(ws_valid), 64'd0);

        // Back-to-back ALU ops with spurious response strobes
        for (int i = 0; i < 5; i++) begin
            es_valid = 1'b1;
            es_bus   = mk_bus(1'b0, 2'd0, 1'b0, 1'b1, 5'(i + 8), 64'(100 + i), 64'(i * 4));
            rdv      = 1'b1;
            d        = {$urandom, $urandom};
            rdata    = d;
            if (i > 0) begin
                #1;
                chk("b2b valid", 64'(ws_valid), 64'd1);
                chk("b2b allowin", 64'(ms_allowin), 64'd1);
                chk("b2b result", ws_bus[127:64], 64'(100 + i - 1));
                chk("b2b pc", dbg_pc, 64'((i - 1) * 4));
            end
            step();
        end
        es_valid = 1'b0;
        #1 chk("b2b last result", ws_bus[127:64], 64'd104);
        step();
        rdv = 1'b0;
        #1 chk("b2b drained", 64'(ws_valid), 64'd0);

        // Reset while a load is pending, response right after
        es_valid = 1'b1;
        es_bus   = mk_bus(1'b0, 2'd0, 1'b1, 1'b1, 5'd9, 64'h3, 64'h300);
        step();
        es_valid = 1'b0;
        resetn   = 1'b0;
        step();
        resetn = 1'b1;
        rdv = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("rst-load valid", 64'(ws_valid), 64'd0);
        chk("rst-load allowin", 64'(ms_allowin), 64'd1);
        chk("rst-load fwd_valid", 64'(fwd_bus[70]), 64'd0);
        step();
        rdv = 1'b0;
        #1 chk("rst-load after", 64'(ws_valid), 64'd0);

        // 32-bit datapath: signed byte at offset 3, then size 3 as full word
        es_valid32 = 1'b1;
        es_bus32   = mk_bus32(1'b0, 2'd0, 1'b1, 1'b1, 5'd5, 32'h3, 32'h40);
        step();
        es_valid32 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("x32 wait valid", 64'(ws_valid32), 64'd0);
            step();
        end
        rdv32 = 1'b1; rdata32 = 32'h8000_0000;
        #1;
        chk("x32 byte valid", 64'(ws_valid32), 64'd1);
        chk("x32 byte result", 64'(ws_bus32[63:32]), 64'h0000_0000_FFFF_FF80);
        step();
        rdv32 = 1'b0;
        es_valid32 = 1'b1;
        es_bus32   = mk_bus32(1'b0, 2'd3, 1'b1, 1'b1, 5'd6, 32'h2, 32'h44);
        step();
        es_valid32 = 1'b0;
        rdv32 = 1'b1; rdata32 = 32'h8000_1234;
        #1;
        chk("x32 dword valid", 64'(ws_valid32), 64'd1);
        chk("x32 dword result", 64'(dbg_res32), 64'h0000_0000_8000_1234);
        chk("x32 dword pc", 64'(dbg_pc32), 64'h44);
        step();
        rdv32 = 1'b0;
        #1 chk("x32 drained", 64'(ws_valid32), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
